// File: rtl/alu_pkg.sv
// Shared types and the golden result function for the 3-bit operand ALU.
// Pure definitions: no latency, no flow control.
package alu_pkg;

   localparam int DW = 3;
   localparam int RW = 6;

   localparam logic [1:0] OP_XNOR = 2'b00;
   localparam logic [1:0] OP_AND  = 2'b01;
   localparam logic [1:0] OP_OR   = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;

   typedef enum logic {
      CHECK = 1'b0,
      HALT  = 1'b1
   } chk_state_e;

   typedef struct packed {
      logic          vld;
      logic [1:0]    op;
      logic [RW-1:0] exp;
   } ref_ent_t;

   function automatic logic [RW-1:0] alu_ref(input logic [1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [RW-1:0] r;
      r = '0;
      case (op)
         OP_XNOR: r = {{(RW-DW){1'b0}}, ~(a ^ b)};
         OP_AND:  r = {{(RW-DW){1'b0}}, a & b};
         OP_OR:   r = {{(RW-DW){1'b0}}, a | b};
         OP_MUL:  r = RW'(a) * RW'(b);
      endcase
      return r;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/alu_ref_pipe.sv
// Delay line carrying {valid, op, expected} from operand sample to the compare tap.
// LAT cycles, shifts every clock with no stall; rst empties every stage.
module alu_ref_pipe
   import alu_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  ref_ent_t in_ent,
   output ref_ent_t tap_ent
);

   ref_ent_t stage_q [LAT];
   ref_ent_t stage_d [LAT];

   always_comb begin
      stage_d[0] = in_ent;
      for (int i = 1; i < LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tap_ent = stage_q[LAT-1];

endmodule

// File: rtl/alu_result_checker.sv
// Compares ALU dout against the golden result LAT cycles after operand sample;
// keeps saturating pass/fail counts and a sticky first-error capture, optional halt on error.
module alu_result_checker
   import alu_pkg::*;
#(
   parameter int LAT         = 1,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [1:0]    op,
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   input  logic [RW-1:0] dout,
   input  logic          clr,
   output logic [7:0]    pass_cnt,
   output logic [7:0]    fail_cnt,
   output logic          err,
   output logic [1:0]    err_op,
   output logic [RW-1:0] err_exp,
   output logic [RW-1:0] err_got,
   output logic          halted
);

   ref_ent_t in_ent;
   ref_ent_t tap_ent;

   always_comb begin
      in_ent     = '0;
      in_ent.vld = en;
      in_ent.op  = op;
      in_ent.exp = alu_ref(op, A, B);
   end

   alu_ref_pipe #(.LAT(LAT)) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_ent  (in_ent),
      .tap_ent (tap_ent)
   );

   chk_state_e    state_q, state_d;
   logic [7:0]    pass_q, pass_d;
   logic [7:0]    fail_q, fail_d;
   logic          err_q, err_d;
   logic [1:0]    err_op_q, err_op_d;
   logic [RW-1:0] err_exp_q, err_exp_d;
   logic [RW-1:0] err_got_q, err_got_d;
   logic          do_cmp;

   // clr outranks a tap arriving on the same edge: that compare is simply dropped
   always_comb begin
      state_d   = state_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_d     = err_q;
      err_op_d  = err_op_q;
      err_exp_d = err_exp_q;
      err_got_d = err_got_q;
      do_cmp    = tap_ent.vld && (state_q == CHECK) && !clr;

      if (clr) begin
         state_d   = CHECK;
         pass_d    = '0;
         fail_d    = '0;
         err_d     = 1'b0;
         err_op_d  = '0;
         err_exp_d = '0;
         err_got_d = '0;
      end else if (do_cmp) begin
         if (dout == tap_ent.exp) begin
            pass_d = sat_inc8(pass_q);
         end else begin
            fail_d = sat_inc8(fail_q);
            if (!err_q) begin
               err_d     = 1'b1;
               err_op_d  = tap_ent.op;
               err_exp_d = tap_ent.exp;
               err_got_d = dout;
            end
            if (STOP_ON_ERR) begin
               state_d = HALT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CHECK;
         pass_q    <= '0;
         fail_q    <= '0;
         err_q     <= 1'b0;
         err_op_q  <= '0;
         err_exp_q <= '0;
         err_got_q <= '0;
      end else begin
         state_q   <= state_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         err_op_q  <= err_op_d;
         err_exp_q <= err_exp_d;
         err_got_q <= err_got_d;
      end
   end

   assign pass_cnt = pass_q;
   assign fail_cnt = fail_q;
   assign err      = err_q;
   assign err_op   = err_op_q;
   assign err_exp  = err_exp_q;
   assign err_got  = err_got_q;
   assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: three instances (LAT=1, LAT=1 halting, LAT=2)
// share one stimulus bus; each scenario resets first and inspects only its instance.
module tb_alu_result_checker;
   import alu_pkg::*;

   logic          clk = 1'b0;
   logic          rst, en, clr;
   logic [1:0]    op;
   logic [DW-1:0] a_in, b_in;
   logic [RW-1:0] dout;

   logic [7:0]    pc1, fc1, pcs, fcs, pc2, fc2;
   logic          er1, ers, er2, h1, hs, h2;
   logic [1:0]    eo1, eos, eo2;
   logic [RW-1:0] ee1, ees, ee2, eg1, egs, eg2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_result_checker #(.LAT(1), .STOP_ON_ERR(1'b0)) u1 (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(a_in), .B(b_in), .dout(dout), .clr(clr),
      .pass_cnt(pc1), .fail_cnt(fc1), .err(er1), .err_op(eo1), .err_exp(ee1),
      .err_got(eg1), .halted(h1));

   alu_result_checker #(.LAT(1), .STOP_ON_ERR(1'b1)) us (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(a_in), .B(b_in), .dout(dout), .clr(clr),
      .pass_cnt(pcs), .fail_cnt(fcs), .err(ers), .err_op(eos), .err_exp(ees),
      .err_got(egs), .halted(hs));

   alu_result_checker #(.LAT(2), .STOP_ON_ERR(1'b0)) u2 (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(a_in), .B(b_in), .dout(dout), .clr(clr),
      .pass_cnt(pc2), .fail_cnt(fc2), .err(er2), .err_op(eo2), .err_exp(ee2),
      .err_got(eg2), .halted(h2));

   typedef struct {
      logic [1:0] op;
      logic [2:0] a;
      logic [2:0] b;
      logic [5:0] exp;
      logic [5:0] dout;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, want);
   endtask

   // Drive one cycle of inputs, then step to just past the next rising edge.
   task automatic push(input logic e, input logic [1:0] o, input logic [2:0] a,
                       input logic [2:0] b, input logic [5:0] d);
      en = e; op = o; a_in = a; b_in = b; dout = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd0);
      rst = 1'b0;
   endtask

   function automatic logic [5:0] tb_ref(input logic [1:0] o, input logic [2:0] a,
                                         input logic [2:0] b);
      logic [5:0] r;
      r = 6'd0;
      case (o)
         2'b00: r = 6'd7 - {3'b000, a ^ b};
         2'b01: r = {3'b000, a & b};
         2'b10: r = {3'b000, a | b};
         default: for (int k = 0; k < 8; k++) if (k < int'(b)) r = r + {3'b000, a};
      endcase
      return r;
   endfunction

   logic [5:0] exp_hist [300];
   logic [1:0] so;
   logic [2:0] sa, sb;
   int mp, mf, first_bad;

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; op = 2'b00; a_in = '0; b_in = '0; dout = '0;

      tbl[0]  = '{2'b00, 3'd3, 3'd1, 6'd5,  6'd5};
      tbl[1]  = '{2'b01, 3'd6, 3'd3, 6'd2,  6'd2};
      tbl[2]  = '{2'b10, 3'd4, 3'd1, 6'd5,  6'd5};
      tbl[3]  = '{2'b11, 3'd7, 3'd7, 6'd49, 6'd48};
      tbl[4]  = '{2'b11, 3'd5, 3'd6, 6'd30, 6'd30};
      tbl[5]  = '{2'b00, 3'd7, 3'd7, 6'd7,  6'd7};
      tbl[6]  = '{2'b00, 3'd0, 3'd7, 6'd0,  6'd0};
      tbl[7]  = '{2'b01, 3'd5, 3'd2, 6'd0,  6'd1};
      tbl[8]  = '{2'b10, 3'd0, 3'd0, 6'd0,  6'd0};
      tbl[9]  = '{2'b11, 3'd0, 3'd5, 6'd0,  6'd0};
      tbl[10] = '{2'b11, 3'd7, 3'd1, 6'd7,  6'd7};
      tbl[11] = '{2'b11, 3'd3, 3'd3, 6'd9,  6'd9};

      // Reset state of every instance
      do_rst();
      chk("rst_pass1", pc1, 0); chk("rst_fail1", fc1, 0); chk("rst_err1", er1, 0);
      chk("rst_eop1", eo1, 0);  chk("rst_eexp1", ee1, 0); chk("rst_egot1", eg1, 0);
      chk("rst_halt1", h1, 0);
      chk("rst_passs", pcs, 0); chk("rst_fails", fcs, 0); chk("rst_errs", ers, 0);
      chk("rst_eops", eos, 0);  chk("rst_eexps", ees, 0); chk("rst_egots", egs, 0);
      chk("rst_halts", hs, 0);
      chk("rst_pass2", pc2, 0); chk("rst_fail2", fc2, 0); chk("rst_err2", er2, 0);
      chk("rst_eop2", eo2, 0);  chk("rst_eexp2", ee2, 0); chk("rst_egot2", eg2, 0);
      chk("rst_halt2", h2, 0);

      // Table vectors on LAT=1: operand, then dout one cycle later
      mp = 0; mf = 0; first_bad = -1;
      for (int i = 0; i < 12; i++) begin
         push(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 6'd0);
         push(1'b0, 2'b00, 3'd0, 3'd0, tbl[i].dout);
         if (tbl[i].dout == tbl[i].exp) mp++;
         else begin
            mf++;
            if (first_bad < 0) first_bad = i;
         end
         chk($sformatf("tbl%0d_pass", i), pc1, mp);
         chk($sformatf("tbl%0d_fail", i), fc1, mf);
      end
      chk("tbl_err", er1, 1);
      chk("tbl_eop", eo1, 3);
      chk("tbl_eexp", ee1, 49);
      chk("tbl_egot", eg1, 48);

      // Bubbles: garbage dout with en=0 must not count
      push(1'b0, 2'b11, 3'd7, 3'd7, 6'h3F);
      push(1'b0, 2'b11, 3'd7, 3'd7, 6'h2A);
      push(1'b0, 2'b00, 3'd1, 3'd2, 6'h15);
      chk("bubble_pass", pc1, mp);
      chk("bubble_fail", fc1, mf);

      // STOP_ON_ERR: mismatch, three correct operands, then clr
      do_rst();
      push(1'b1, OP_AND, 3'd7, 3'd7, 6'd0);
      push(1'b1, OP_OR, 3'd1, 3'd2, 6'd0);
      push(1'b1, OP_OR, 3'd4, 3'd1, 6'd3);
      push(1'b1, OP_XNOR, 3'd0, 3'd0, 6'd5);
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd7);
      chk("stop_halted", hs, 1);
      chk("stop_pass", pcs, 0);
      chk("stop_fail", fcs, 1);
      chk("stop_err", ers, 1);
      chk("stop_egot", egs, 0);
      clr = 1'b1;
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd0);
      clr = 1'b0;
      chk("clr_halted", hs, 0);
      chk("clr_pass", pcs, 0);
      chk("clr_fail", fcs, 0);
      chk("clr_err", ers, 0);
      chk("clr_eexp", ees, 0);
      push(1'b1, OP_MUL, 3'd2, 3'd3, 6'd0);
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd6);
      chk("resume_pass", pcs, 1);

      // LAT=2 full-rate stream of 300 matches, then one mismatch
      do_rst();
      so = '0; sa = '0; sb = '0;
      for (int j = 0; j < 302; j++) begin
         if (j < 300) begin
            so = 2'(j % 4); sa = 3'(j % 8); sb = 3'((j / 8) % 8);
            exp_hist[j] = tb_ref(so, sa, sb);
         end
         push(j < 300, so, sa, sb, (j >= 2) ? exp_hist[j-2] : 6'd0);
      end
      chk("sat_pass", pc2, 255);
      chk("sat_fail", fc2, 0);
      push(1'b1, OP_MUL, 3'd7, 3'd7, 6'd0);
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd0);
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd48);
      chk("sat_mis_fail", fc2, 1);
      chk("sat_mis_pass", pc2, 255);
      chk("sat_mis_err", er2, 1);
      chk("sat_mis_eexp", ee2, 49);

      // rst mid-stream on LAT=2 drops in-flight operands
      do_rst();
      push(1'b1, OP_AND, 3'd3, 3'd6, 6'd0);
      push(1'b1, OP_OR, 3'd3, 3'd4, 6'd0);
      rst = 1'b1;
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd2);
      rst = 1'b0;
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd7);
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd0);
      chk("midrst_pass", pc2, 0);
      chk("midrst_fail", fc2, 0);

      // clr on a mismatch tap discards it; operand sampled alongside clr still checks
      do_rst();
      push(1'b1, OP_OR, 3'd1, 3'd1, 6'd0);
      clr = 1'b1;
      push(1'b1, OP_MUL, 3'd3, 3'd5, 6'd0);
      clr = 1'b0;
      chk("clrtap_fail", fc1, 0);
      chk("clrtap_err", er1, 0);
      chk("clrtap_pass", pc1, 0);
      push(1'b0, 2'b00, 3'd0, 3'd0, 6'd14);
      chk("post_clr_fail", fc1, 1);
      chk("post_clr_err", er1, 1);
      chk("post_clr_eop", eo1, 3);
      chk("post_clr_eexp", ee1, 15);
      chk("post_clr_egot", eg1, 14);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Result-side checker for the 3-bit operand ALU. It samples the same operand/op/enable bus the ALU sees and computes the expected 6-bit result. That expected value is delayed through a LAT-deep pipeline and compared against the ALU's result bus. Pass/fail counts and a sticky first-error capture are kept for the bench and for on-chip self-test.

## Interface
- LAT, 1: ALU result latency in clock cycles from operand sample to result valid; legal range 1..4.
- STOP_ON_ERR, 0: 1 = stop comparing after the first mismatch until `clr`; 0 = keep counting.
- clk  in  1  clock; all sampling on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- en  in  1  operand valid; the operands and op on this cycle are checked.
- op  in  2  ALU opcode.
- A  in  3  operand A.
- B  in  3  operand B.
- dout  in  6  ALU result under check.
- clr  in  1  synchronous clear of counters, error capture and state; the pipeline is not flushed.
- pass_cnt  out  8  matching compares, saturating at 255.
- fail_cnt  out  8  mismatching compares, saturating at 255.
- err  out  1  sticky: at least one mismatch since the last rst/clr.
- err_op  out  2  op of the first mismatch.
- err_exp  out  6  expected result of the first mismatch.
- err_got  out  6  dout value at the first mismatch.
- halted  out  1  high in state HALT.

## Operation
- Expected result, all 6 bits:
  - op=00 XNOR: {3'b000, ~(A^B)}.
  - op=01 AND: {3'b000, A&B}.
  - op=10 OR: {3'b000, A|B}.
  - op=11 MUL: A*B, unsigned; 7*7=49 fits in 6 bits, so there is no overflow.
- Pipeline: {valid=en, op, exp} enters stage 1 on every clock. The compare tap is stage LAT.
- A compare happens on a clock where tap valid=1 and state=CHECK:
  - Match (dout == exp): pass_cnt+1.
  - Mismatch: fail_cnt+1.
  - The first mismatch since rst/clr loads err_op/err_exp/err_got and sets err. Later mismatches leave the capture unchanged.
- Both counters saturate at 255; a further event holds the value.
- State machine:
  - CHECK: default state after rst.
  - CHECK -> HALT on a mismatch when STOP_ON_ERR=1.
  - HALT: no counter or capture updates. The pipeline keeps shifting.
  - HALT -> CHECK on clr.
- clr: zeroes the counters, err and the err_* fields, and forces state to CHECK.
- clr and a compare tap on the same cycle: clr wins; that compare is discarded and counted nowhere.
- rst: clears all pipeline valid bits as well as everything clr clears.

## Timing
- Reset values: pass_cnt=0, fail_cnt=0, err=0, err_op=0, err_exp=0, err_got=0, halted=0; state=CHECK; all pipeline valid bits cleared.
- Operands sampled with en=1 at edge t are compared against dout present at edge t+LAT.
- Counter, err and halted updates are visible after edge t+LAT, i.e. on the following cycle.
- Back-to-back en=1 is supported at full rate, one compare per cycle.
- After rst, no compare occurs until the first en=1 operand reaches the tap.
- rst asserted mid-stream: in-flight operands are dropped and never compared.
- clr asserted mid-stream: in-flight operands are compared normally from the next cycle onward.
- en=0 cycles insert bubbles that produce no compare; dout is ignored on those cycles.
- Mismatch on the same cycle pass_cnt or fail_cnt is already 255: err and the capture still update.

## Structure
- Package alu_pkg holds:
  - OP_XNOR=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_MUL=2'b11.
  - DW=3 (operand width) and RW=6 (result width).
  - Pure function alu_ref(op, A, B) returning RW bits, shared with the ALU bench.
  - State enum {CHECK, HALT}.
- Sub-module alu_ref_pipe: parameterised by LAT; carries {valid, op, exp} through the delay line; synchronous clear of valid bits on rst.
- Top level holds the compare, the counters, the error capture and the state machine.

## Test plan
- LAT=1, en=1, op=00, A=3'b011, B=3'b001, dout=6'b000101 one cycle later -> pass_cnt=1, err=0.
- LAT=1, op=11, A=7, B=7, dout=6'd48 one cycle later -> fail_cnt=1, err=1, err_op=11, err_exp=49, err_got=48.
- STOP_ON_ERR=1: mismatch, then 3 correct operands -> halted=1, pass_cnt unchanged. Then clr -> halted=0, all counters 0.
- LAT=2: 300 consecutive matching operands -> pass_cnt saturates at 255. Then one mismatch -> fail_cnt=1, pass_cnt=255.
- en=1 for 2 operands, then rst on the next edge, then correct dout -> counters stay 0.
- clr on the same edge as a mismatch tap -> fail_cnt=0, err=0. A following mismatch -> fail_cnt=1 and the capture holds that second case.
